// File: rtl/unmap9v3.sv
// Receive-side inverse of map9v3: replays the 8-bit XNOR LFSR from seed 0 and
// counts steps until the state matches dp[8:1], recovering the original argument.
module unmap9v3 #(
  parameter logic [7:0] STEP_OFFSET = 8'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] dp,
  output logic [8:0] N,
  output logic       done,
  output logic       error,
  output logic [7:0] counter,
  output logic [7:0] sr
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    INIT   = 4'b0010,
    SEARCH = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  state_t     state;
  logic [1:0] startbuf;
  logic       go;
  logic [7:0] target;
  logic       n0;

  assign go = startbuf[0] & ~startbuf[1];

  // One comparison per SEARCH cycle; the match test wins over the period bound
  // so a match on the last reachable state still succeeds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      startbuf <= 2'b00;
      target   <= 8'd0;
      n0       <= 1'b0;
      N        <= 9'd0;
      done     <= 1'b0;
      error    <= 1'b0;
      counter  <= 8'd0;
      sr       <= 8'd0;
    end else begin
      startbuf <= {startbuf[0], start};
      case (state)
        IDLE: begin
          if (go)
            state <= INIT;
        end
        INIT: begin
          target  <= dp[8:1];
          n0      <= dp[0];
          sr      <= 8'd0;
          counter <= 8'd0;
          done    <= 1'b0;
          error   <= 1'b0;
          state   <= SEARCH;
        end
        SEARCH: begin
          if (sr == target) begin
            N     <= {counter + STEP_OFFSET, n0};
            state <= DONE;
          end else if (counter == 8'd254) begin
            error <= 1'b1;
            N     <= 9'd0;
            state <= DONE;
          end else begin
            sr      <= {sr[6:0], ~(sr[3] ^ sr[4] ^ sr[5] ^ sr[7])};
            counter <= counter + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unmap9v3.sv
// Self-checking bench for unmap9v3: directed corner cases plus random words
// checked against a table-driven model of the LFSR sequence.
module tb_unmap9v3;

  localparam logic [7:0] OFF = 8'd0;

  logic       clock;
  logic       reset;
  logic       start;
  logic [8:0] dp;
  logic [8:0] N;
  logic       done;
  logic       error;
  logic [7:0] counter;
  logic [7:0] sr;

  int testsRun;
  int testsFailed;

  logic [7:0] seqTable [0:255];

  unmap9v3 #(.STEP_OFFSET(OFF)) dut (
    .clock(clock), .reset(reset), .start(start), .dp(dp),
    .N(N), .done(done), .error(error), .counter(counter), .sr(sr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The sequence of LFSR states: seqTable[k] is the state after k steps from 0.
  task automatic build_table();
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 256; k++) begin
      seqTable[k] = s;
      s = {s[6:0], ~(s[3] ^ s[4] ^ s[5] ^ s[7])};
    end
  endtask

  // Reference: first step index within one period whose state equals the target.
  task automatic ref_unmap(input logic [8:0] d, output logic [8:0] expN,
                           output logic expErr, output int expK);
    logic [7:0] kk;
    expK = -1;
    for (int k = 0; k < 255; k++)
      if (expK < 0 && seqTable[k] == d[8:1]) expK = k;
    if (expK >= 0) begin
      kk = 8'(expK);
      expN = {kk + OFF, d[0]};
      expErr = 1'b0;
    end else begin
      expN = 9'd0;
      expErr = 1'b1;
      expK = 254;
    end
  endtask

  // Raises start, measures cycles from the start edge to done, drops start.
  task automatic do_op(input logic [8:0] dpv, input bit perturb,
                       output int cyc, output logic initDone);
    bit seen;
    seen = 0;
    cyc = -1;
    initDone = 1'bx;
    @(posedge clock); #1;
    start = 1'b1;
    dp = dpv;
    for (int c = 1; c <= 300; c++) begin
      if (!seen) begin
        @(posedge clock); #1;
        if (c == 3) begin
          initDone = done;
          if (perturb) dp = 9'($urandom);
        end
        if (c > 3 && done) begin
          seen = 1;
          cyc = c;
        end
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_op(input string name, input logic [8:0] dpv, input bit perturb);
    logic [8:0] expN;
    logic       expErr;
    int         expK;
    int         cyc;
    logic       initDone;
    ref_unmap(dpv, expN, expErr, expK);
    do_op(dpv, perturb, cyc, initDone);
    testsRun++;
    if (initDone !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s init_done: got %b want 0", name, initDone);
    end
    testsRun++;
    if (cyc !== expK + 5) begin
      testsFailed++;
      $display("[TB] FAIL %s latency: got %0d want %0d (dp=%h)", name, cyc, expK + 5, dpv);
    end
    testsRun++;
    if (N !== expN || error !== expErr || done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL %s result: got N=%h err=%b done=%b want N=%h err=%b done=1 (dp=%h)",
               name, N, error, done, expN, expErr, dpv);
    end
    testsRun++;
    if (counter !== 8'(expK) || sr !== seqTable[expK]) begin
      testsFailed++;
      $display("[TB] FAIL %s final: got counter=%0d sr=%h want counter=%0d sr=%h",
               name, counter, sr, expK, seqTable[expK]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dp = 9'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    testsRun++;
    if (N !== 9'd0 || done !== 1'b0 || error !== 1'b0 || counter !== 8'd0 || sr !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: got N=%h done=%b err=%b counter=%h sr=%h want all 0",
               N, done, error, counter, sr);
    end
  endtask

  task automatic test_match_k0();
    check_op("k0", 9'h001, 1'b0);
  endtask

  task automatic test_match_k1();
    check_op("k1", {8'h01, 1'b0}, 1'b0);
  endtask

  task automatic test_lockup_target();
    check_op("lockup", 9'h1FE, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      check_op("random", 9'($urandom), 1'b1);
  endtask

  task automatic test_reset_mid_search();
    bit reached;
    reached = 0;
    @(posedge clock); #1;
    start = 1'b1;
    dp = 9'h1FE;
    for (int c = 0; c < 100; c++) begin
      if (!reached) begin
        @(posedge clock); #1;
        if (counter == 8'd37) reached = 1;
      end
    end
    testsRun++;
    if (!reached) begin
      testsFailed++;
      $display("[TB] FAIL mid_reach: got counter=%0d want 37 within 100 cycles", counter);
    end
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if (N !== 9'd0 || done !== 1'b0 || error !== 1'b0 || counter !== 8'd0 || sr !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: got N=%h done=%b err=%b counter=%h sr=%h want all 0",
               N, done, error, counter, sr);
    end
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    check_op("after_reset", {seqTable[20], 1'b1}, 1'b0);
  endtask

  task automatic test_held_start();
    int   rises;
    logic prevDone;
    rises = 0;
    @(posedge clock); #1;
    prevDone = done;
    start = 1'b1;
    dp = {seqTable[100], 1'b0};
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #1;
      if (done && !prevDone) rises++;
      prevDone = done;
    end
    testsRun++;
    if (rises !== 1 || counter !== 8'd100 || N !== {8'd100 + OFF, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL held_start: got rises=%0d counter=%0d N=%h want rises=1 counter=100 N=%h",
               rises, counter, N, {8'd100 + OFF, 1'b0});
    end
    start = 1'b0;
    repeat (3) @(posedge clock);
    check_op("second_edge", {seqTable[100], 1'b0}, 1'b0);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    build_table();
    test_reset();
    test_match_k0();
    test_match_k1();
    test_lockup_target();
    test_random();
    test_reset_mid_search();
    test_held_start();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
